// File: rtl/ifns_decoder_5.sv
// ifns_decoder_5: 2-stage valid/ready decoder from 5-bit IFNS codewords to 4-bit data.
// Optional saturating illegal-codeword counter enabled by macro IFNS_DECODER_ERRCNT_EN.
module ifns_decoder_5 (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [5:1] codein,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [3:0] dataout,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       err_flag,
    output logic [7:0] err_count
);
    logic [5:1] s1_code;
    logic       s1_valid;
    logic       adv2;
    logic       illegal;
    logic [3:0] dec;
    assign ready_in = ready_out | ~s1_valid | ~valid_out;
    assign adv2     = ready_out | ~valid_out;
    // an interior bit that differs from both neighbours forms 010 or 101
    assign illegal  = |((s1_code[4:2] ^ s1_code[5:3]) & (s1_code[4:2] ^ s1_code[3:1]));
    // legal codewords in ascending order carry data 0..F
    always_comb begin
        dec = 4'h0;
        case (s1_code)
            5'd0:  dec = 4'h0;
            5'd1:  dec = 4'h1;
            5'd3:  dec = 4'h2;
            5'd6:  dec = 4'h3;
            5'd7:  dec = 4'h4;
            5'd12: dec = 4'h5;
            5'd14: dec = 4'h6;
            5'd15: dec = 4'h7;
            5'd16: dec = 4'h8;
            5'd17: dec = 4'h9;
            5'd19: dec = 4'hA;
            5'd24: dec = 4'hB;
            5'd25: dec = 4'hC;
            5'd28: dec = 4'hD;
            5'd30: dec = 4'hE;
            5'd31: dec = 4'hF;
            default: dec = 4'h0;
        endcase
    end
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_code   <= '0;
            s1_valid  <= 1'b0;
            dataout   <= 4'h0;
            err_flag  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            if (ready_in) begin
                s1_code  <= codein;
                s1_valid <= valid_in;
            end
            if (adv2) begin
                valid_out <= s1_valid;
                if (s1_valid) begin
                    dataout  <= illegal ? 4'h0 : dec;
                    err_flag <= illegal;
                end
            end
        end
    end
`ifdef IFNS_DECODER_ERRCNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'h00;
        else if (valid_out && ready_out && err_flag && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
    end
`else
    assign err_count = 8'h00;
`endif
endmodule
